// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// one-entry holding buffer that keeps a returned instruction while the
// pipeline is stalled. Branch redirects override stalls and every state.
// Optional stall cycle counter is built when FETCH_STALL_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_write,
    input  logic        IFID_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_pc4,
    output logic        IFID_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [0:0] {StFetch, StHold} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] buffer_q, buffer_d;
    logic        stall;
    logic [31:0] pc_plus4;

    assign stall    = !PC_write || !IFID_write;
    // Natural 32-bit overflow gives the required wrap to zero.
    assign pc_plus4 = pc_q + 32'd4;

    // State register and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            buffer_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            buffer_q     <= buffer_d;
        end
    end

    // Next-state logic: a response arriving under stall parks us in HOLD
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch: if (imem_ready && stall) state_d = StHold;
                StHold:  if (!stall) state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    // Datapath next values for PC, IF/ID and the holding buffer
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        buffer_d     = buffer_q;
        if (branch_taken) begin
            // Redirect drops any coincident response and the buffered word.
            pc_d         = {branch_target[31:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            buffer_d     = 32'h0;
        end else if (state_q == StFetch) begin
            if (imem_ready && !stall) begin
                pc_d         = pc_plus4;
                ifid_instr_d = imem_rdata;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = 1'b1;
            end else if (imem_ready && stall) begin
                buffer_d = imem_rdata;
            end else if (!imem_ready && !stall) begin
                ifid_instr_d = NOP_INSTR;
                ifid_pc4_d   = pc_plus4;
                ifid_valid_d = 1'b0;
            end
        end else if (!stall) begin
            pc_d         = pc_plus4;
            ifid_instr_d = buffer_q;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    // Output logic: request only in FETCH and never while reset is held
    always_comb begin
        imem_req = rst && (state_q == StFetch);
    end

    assign imem_addr  = pc_q;
    assign IFID_instr = ifid_instr_q;
    assign IFID_pc4   = ifid_pc4_q;
    assign IFID_valid = ifid_valid_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stalled cycles that are not overridden by a branch
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0;
        end else if (stall && !branch_taken && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0000, giving the instruction word used for bubbles.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low.
REQ-005 PC_write  in  1  from hazard unit; 0 = hold PC.
REQ-006 IFID_write  in  1  from hazard unit; 0 = hold IF/ID register.
REQ-007 branch_taken  in  1  redirect request from ID/EX.
REQ-008 branch_target  in  32  redirect address.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  fetch address, always equal to PC.
REQ-011 imem_ready  in  1  instruction memory response valid.
REQ-012 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-013 IFID_instr  out  32  registered instruction to ID.
REQ-014 IFID_pc4  out  32  registered PC+4 of that instruction.
REQ-015 IFID_valid  out  1  1 = IFID_instr is real, 0 = bubble.
REQ-016 stall_cnt  out  16  stall cycle counter (present only per REQ-033).

Function
REQ-017 Stall SHALL be defined as (PC_write==0 || IFID_write==0); both IF/ID and PC hold on stall.
REQ-018 The FSM SHALL have states FETCH (imem_req=1) and HOLD (imem_req=0, buffered instruction pending).
REQ-019 In FETCH with imem_ready=1 and no stall, the block SHALL load IF/ID with {imem_rdata, PC+4, valid=1} and set PC<=PC+4 in the same edge; one instruction per cycle at full rate.
REQ-020 In FETCH with imem_ready=1 and stall, the block SHALL capture imem_rdata into a 32-bit holding buffer, keep PC and IF/ID unchanged, and enter HOLD.
REQ-021 In FETCH with imem_ready=0 and no stall, IF/ID SHALL load a bubble {NOP_INSTR, PC+4, valid=0}; PC unchanged.
REQ-022 In FETCH with imem_ready=0 and stall, IF/ID and PC SHALL hold.
REQ-023 In HOLD with no stall, IF/ID SHALL load {buffer, PC+4, valid=1}, PC<=PC+4, next state FETCH; in HOLD with stall, all state holds; imem_ready is ignored in HOLD.
REQ-024 branch_taken=1 SHALL override stall and every state: PC<=branch_target with bits [1:0] forced to 00, IF/ID<=bubble {NOP_INSTR, 0, valid=0}, buffer discarded, next state FETCH, any coincident imem response dropped.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error flag.
REQ-026 imem_addr SHALL be combinationally equal to the PC register; imem_req SHALL be a function of state and rst only.

Reset
REQ-027 While rst=0 at a rising edge: PC<=RESET_PC, state<=FETCH, IF/ID<={NOP_INSTR, 0, valid=0}, buffer<=0, stall_cnt<=0.
REQ-028 imem_req SHALL be 0 while rst=0, and 1 in the first cycle after rst returns to 1.
REQ-029 Reset asserted mid-HOLD or mid-branch SHALL take precedence over all other inputs and discard the buffered instruction.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN SHALL control the stall counter.
REQ-031 With FETCH_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle in which stall=1 and branch_taken=0, saturating at 16'hFFFF.
REQ-032 Without FETCH_STALL_CNT_EN: port stall_cnt and its register SHALL be absent; all other behaviour identical.
REQ-033 Port list of REQ-016 SHALL exist only when FETCH_STALL_CNT_EN is defined.

Verification
REQ-034 Reset with RESET_PC=32'h100, imem_ready=1 constant, no stall -> imem_addr 0x100,0x104,0x108 on consecutive cycles; IFID_pc4 0x104,0x108 with valid=1.
REQ-035 Load-use stall: PC_write=IFID_write=0 for 1 cycle while imem_ready=1 returns word 0xAABBCCDD at PC 0x108 -> HOLD entered, IF/ID unchanged, next cycle IF/ID={0xAABBCCDD, 0x10C, 1}, no duplicate or lost instruction.
REQ-036 branch_taken=1, branch_target=32'h203 during a stall in HOLD -> next cycle PC=0x200, IFID_valid=0, buffer discarded, imem_req=1.
REQ-037 imem_ready=0 for 3 cycles, no stall -> 3 bubbles with IFID_valid=0, PC holds, then normal fetch resumes.
REQ-038 PC=32'hFFFF_FFFC fetch -> PC wraps to 0, IFID_pc4=0.
REQ-039 With FETCH_STALL_CNT_EN: 5 stall cycles, one overlapping branch_taken -> stall_cnt=4; preload to 16'hFFFF then stall -> stays 16'hFFFF.
